// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the fetch/data memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY)
//   owner_t     : requester that owns the access in flight
//   cnt_w()     : bit width needed to hold a counter value 0..max_val
package mem_port_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 16;
   localparam int unsigned MEM_DATA_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   function automatic int unsigned cnt_w(input int unsigned max_val);
      int unsigned w;
      w = 1;
      while ((max_val >> w) != 0) w++;
      return w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, data port, unified memory port and status lines
//   of the arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives
//            grants, read data, memory access, cpu_stall, err)
//   master : environment view (cpu core plus memory)
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned DATA_W = MEM_DATA_W
) ();

   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   // unified memory
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // status
   logic              cpu_stall;
   logic              err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, err
   );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick
//   Combinational grant selection for the memory port arbiter.
//   accept_i : arbiter can take a new access this cycle
//   if_req_i : fetch request
//   d_req_i  : data request
//   streak_i : consecutive data grants taken while fetch was waiting
//   if_gnt_o : fetch granted
//   d_gnt_o  : data granted
module arb_pick #(
   parameter int unsigned MAX_DSTREAK = 3,
   parameter int unsigned STRK_W      = 2
) (
   input  logic              accept_i,
   input  logic              if_req_i,
   input  logic              d_req_i,
   input  logic [STRK_W-1:0] streak_i,
   output logic              if_gnt_o,
   output logic              d_gnt_o
);

   logic fetch_turn;

   always_comb begin
      fetch_turn = (streak_i == STRK_W'(MAX_DSTREAK));
      if_gnt_o   = 1'b0;
      d_gnt_o    = 1'b0;
      if (accept_i) begin
         if (if_req_i && d_req_i) begin
            // data wins unless fetch has already waited out its streak
            if_gnt_o = fetch_turn;
            d_gnt_o  = ~fetch_turn;
         end else begin
            if_gnt_o = if_req_i;
            d_gnt_o  = d_req_i;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported word memory between instruction fetch and
//   data (load/store) requesters. Data wins by default; after MAX_DSTREAK
//   consecutive data grants with fetch waiting, fetch is served. A new
//   access is accepted in IDLE or in the cycle the current one completes.
//   Accesses without mem_ready for TIMEOUT BUSY cycles are aborted.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch/data/memory/status signals (mem_port_arbiter_if.slave)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = MEM_ADDR_W,
   parameter int unsigned DATA_W      = MEM_DATA_W,
   parameter int unsigned MAX_DSTREAK = 3,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned TMR_W  = cnt_w(TIMEOUT);
   localparam int unsigned STRK_W = cnt_w(MAX_DSTREAK);

   arb_state_t        state_q,     state_d;
   owner_t            owner_q,     owner_d;
   logic              we_q,        we_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic [TMR_W-1:0]  timer_q,     timer_d;
   logic [STRK_W-1:0] streak_q,    streak_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic              d_rvalid_q,  d_rvalid_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              err_q,       err_d;

   logic accept;
   logic done;
   logic abort;
   logic if_gnt;
   logic d_gnt;

   assign done   = (state_q == BUSY) && bus.mem_ready;
   assign abort  = (state_q == BUSY) && !bus.mem_ready &&
                   (timer_q == TMR_W'(TIMEOUT - 1));
   // reset gates the accept slot so no grant escapes while reset is held
   assign accept = !reset && ((state_q == IDLE) || done);

   arb_pick #(
      .MAX_DSTREAK (MAX_DSTREAK),
      .STRK_W      (STRK_W)
   ) u_pick (
      .accept_i (accept),
      .if_req_i (bus.if_req),
      .d_req_i  (bus.d_req),
      .streak_i (streak_q),
      .if_gnt_o (if_gnt),
      .d_gnt_o  (d_gnt)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         timer_q     <= '0;
         streak_q    <= '0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         timer_q     <= timer_d;
         streak_q    <= streak_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   // next state
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      timer_d     = timer_q;
      streak_d    = streak_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rvalid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: ;
         BUSY: begin
            if (bus.mem_ready) begin
               if (owner_q == OWN_IF) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_rdata;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = we_q ? '0 : bus.mem_rdata;
               end
               state_d = IDLE;
               we_d    = 1'b0;
            end else if (abort) begin
               // release the owner with a zero response and flag the error
               err_d = 1'b1;
               if (owner_q == OWN_IF) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = '0;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = '0;
               end
               state_d = IDLE;
               we_d    = 1'b0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // a grant in the completion cycle overrides the return to IDLE
      if (if_gnt || d_gnt) begin
         state_d = BUSY;
         timer_d = '0;
         owner_d = d_gnt ? OWN_D : OWN_IF;
         we_d    = d_gnt && bus.d_we;
         addr_d  = d_gnt ? bus.d_addr : bus.if_addr;
         wdata_d = d_gnt ? bus.d_wdata : '0;
      end

      if (if_gnt) begin
         streak_d = '0;
      end else if (d_gnt) begin
         if (!bus.if_req) begin
            streak_d = '0;
         end else if (streak_q != STRK_W'(MAX_DSTREAK)) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   // outputs
   always_comb begin
      bus.if_gnt    = if_gnt;
      bus.d_gnt     = d_gnt;
      bus.cpu_stall = bus.if_req && !if_gnt;
      bus.mem_en    = (state_q == BUSY);
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.if_rvalid = if_rvalid_q;
      bus.if_rdata  = if_rdata_q;
      bus.d_rvalid  = d_rvalid_q;
      bus.d_rdata   = d_rdata_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench: directed scenarios plus randomized traffic, all
//   compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned MAXS = 3;
   localparam int unsigned TMO  = 15;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_port_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .MAX_DSTREAK (MAXS),
      .TIMEOUT     (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: one outstanding access, its age, and the fetch-wait streak
   bit          m_busy, m_own_d, m_we;
   logic [15:0] m_addr, m_wdata;
   int unsigned m_age, m_streak;
   bit          e_if_rv, e_d_rv, e_err;
   logic [15:0] e_if_rd, e_d_rd;
   bit          m_gi, m_gd;

   task automatic model_reset();
      m_busy = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_age = 0; m_streak = 0;
      e_if_rv = 0; e_d_rv = 0; e_err = 0; e_if_rd = '0; e_d_rd = '0;
      m_gi = 0; m_gd = 0;
   endtask

   // wait for negedge, predict grants, compare all outputs
   task automatic sample();
      bit acc;
      @(negedge clk);
      acc  = !m_busy || bus.mem_ready;
      m_gi = 0;
      m_gd = 0;
      if (acc) begin
         if (bus.if_req && bus.d_req) begin
            if (m_streak >= MAXS) m_gi = 1; else m_gd = 1;
         end else begin
            m_gi = bus.if_req;
            m_gd = bus.d_req;
         end
      end
      chk("if_gnt",    32'(bus.if_gnt),    32'(m_gi));
      chk("d_gnt",     32'(bus.d_gnt),     32'(m_gd));
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.if_req && !m_gi));
      chk("mem_en",    32'(bus.mem_en),    32'(m_busy));
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
      chk("d_rvalid",  32'(bus.d_rvalid),  32'(e_d_rv));
      chk("err",       32'(bus.err),       32'(e_err));
      chk("if_rdata",  32'(bus.if_rdata),  32'(e_if_rd));
      chk("d_rdata",   32'(bus.d_rdata),   32'(e_d_rd));
      if (m_busy) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
         chk("mem_we",   32'(bus.mem_we),   32'(m_we));
         if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      end
   endtask

   // apply this cycle's inputs to the model, then move to posedge+1
   task automatic advance();
      e_if_rv = 0;
      e_d_rv  = 0;
      e_err   = 0;
      if (m_busy) begin
         if (bus.mem_ready) begin
            if (m_own_d) begin
               e_d_rv = 1;
               e_d_rd = m_we ? 16'h0000 : bus.mem_rdata;
            end else begin
               e_if_rv = 1;
               e_if_rd = bus.mem_rdata;
            end
            m_busy = 0;
         end else begin
            m_age++;
            if (m_age == TMO) begin
               e_err = 1;
               if (m_own_d) begin e_d_rv = 1; e_d_rd = '0; end
               else begin e_if_rv = 1; e_if_rd = '0; end
               m_busy = 0;
            end
         end
      end
      if (m_gi || m_gd) begin
         m_busy  = 1;
         m_age   = 0;
         m_own_d = m_gd;
         m_we    = m_gd && bus.d_we;
         m_addr  = m_gd ? bus.d_addr : bus.if_addr;
         m_wdata = bus.d_wdata;
         if (m_gi || !bus.if_req) m_streak = 0;
         else if (m_streak < MAXS) m_streak++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
   endtask

   bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
      chk("rst_err",       32'(bus.err),       32'd0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      chk("rst_d_rdata",   32'(bus.d_rdata),   32'd0);
      reset = 1'b0;

      // fetch only
      bus.if_req = 1; bus.if_addr = 16'h0010;
      sample();
      chk("f_if_gnt", 32'(bus.if_gnt), 32'd1);
      chk("f_stall",  32'(bus.cpu_stall), 32'd0);
      advance();
      bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 16'hE3A1;
      sample();
      chk("f_mem_en",   32'(bus.mem_en),   32'd1);
      chk("f_mem_addr", 32'(bus.mem_addr), 32'h0010);
      advance();
      bus.mem_ready = 0;
      sample();
      chk("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("f_if_rdata",  32'(bus.if_rdata),  32'hE3A1);
      advance();

      // contention with mem_ready always high
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 0; bus.mem_ready = 1;
      for (int i = 0; i < 8; i++) begin
         bus.if_addr   = 16'h0100 + 16'(i);
         bus.d_addr    = 16'h0800 + 16'(i);
         bus.mem_rdata = 16'($urandom);
         sample();
         chk("cont_d_gnt", 32'(bus.d_gnt),     32'(pat[i]));
         chk("cont_stall", 32'(bus.cpu_stall), 32'(pat[i]));
         advance();
      end
      bus.if_req = 0; bus.d_req = 0;
      sample(); advance();
      bus.mem_ready = 0;
      sample(); advance();

      // store
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
      sample();
      chk("st_d_gnt", 32'(bus.d_gnt), 32'd1);
      advance();
      bus.d_req = 0; bus.d_we = 0; bus.mem_ready = 1; bus.mem_rdata = 16'hFFFF;
      sample();
      chk("st_mem_we",    32'(bus.mem_we),    32'd1);
      chk("st_mem_addr",  32'(bus.mem_addr),  32'h0200);
      chk("st_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      advance();
      bus.mem_ready = 0;
      sample();
      chk("st_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("st_d_rdata",  32'(bus.d_rdata),  32'h0000);
      advance();

      // timeout on a load
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0300;
      sample(); advance();
      bus.d_req = 0;
      for (int i = 0; i < int'(TMO); i++) begin
         sample();
         chk("to_busy_en",  32'(bus.mem_en), 32'd1);
         chk("to_busy_err", 32'(bus.err),    32'd0);
         advance();
      end
      bus.if_req = 1; bus.if_addr = 16'h0044;
      sample();
      chk("to_err",      32'(bus.err),      32'd1);
      chk("to_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("to_d_rdata",  32'(bus.d_rdata),  32'd0);
      chk("to_mem_en",   32'(bus.mem_en),   32'd0);
      chk("to_if_gnt",   32'(bus.if_gnt),   32'd1);
      advance();
      bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 16'h5A5A;
      sample(); advance();
      bus.mem_ready = 0;
      sample(); advance();

      // back-to-back
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0400;
      sample(); advance();
      bus.d_req = 0; bus.if_req = 1; bus.if_addr = 16'h0050;
      bus.mem_ready = 1; bus.mem_rdata = 16'hBEEF;
      sample();
      chk("b2b_if_gnt", 32'(bus.if_gnt), 32'd1);
      advance();
      bus.if_req = 0; bus.mem_ready = 0;
      sample();
      chk("b2b_mem_en",   32'(bus.mem_en),   32'd1);
      chk("b2b_mem_addr", 32'(bus.mem_addr), 32'h0050);
      chk("b2b_d_rdata",  32'(bus.d_rdata),  32'hBEEF);
      advance();
      bus.mem_ready = 1;
      sample(); advance();
      bus.mem_ready = 0;
      sample(); advance();

      // randomized traffic: first half fast memory, second half slow enough to time out
      for (int i = 0; i < 3000; i++) begin
         if (!bus.if_req || m_gi || ($urandom_range(15) == 0)) begin
            bus.if_req  = ($urandom_range(3) != 0);
            bus.if_addr = 16'($urandom);
         end
         if (!bus.d_req || m_gd || ($urandom_range(15) == 0)) begin
            bus.d_req   = ($urandom_range(3) != 0);
            bus.d_we    = 1'($urandom);
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
         end
         bus.mem_ready = (i < 1500) ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
         bus.mem_rdata = 16'($urandom);
         sample();
         advance();
      end

      // reset asserted mid-access
      idle_inputs();
      sample(); advance();
      sample(); advance();
      bus.d_req = 1; bus.d_addr = 16'h0123;
      sample(); advance();
      bus.d_req = 0;
      sample(); advance();
      bus.if_req = 1; bus.mem_ready = 1;
      #1;
      chk("rb_busy", 32'(bus.mem_en), 32'd1);
      reset = 1'b1;
      #1;
      chk("rb_mem_en",    32'(bus.mem_en),    32'd0);
      chk("rb_if_gnt",    32'(bus.if_gnt),    32'd0);
      chk("rb_d_gnt",     32'(bus.d_gnt),     32'd0);
      chk("rb_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("rb_d_rvalid",  32'(bus.d_rvalid),  32'd0);
      chk("rb_err",       32'(bus.err),       32'd0);
      chk("rb_stall",     32'(bus.cpu_stall), 32'd1);
      model_reset();
      bus.if_req = 0; bus.mem_ready = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sample(); advance();
      bus.if_req = 1; bus.if_addr = 16'h0777;
      sample();
      chk("rb_idle_gnt", 32'(bus.if_gnt), 32'd1);
      advance();
      bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 16'h0F0F;
      sample(); advance();
      bus.mem_ready = 0;
      sample(); advance();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
